axi_write_burst: RTL and testbench
==================================

Name: axi_write_burst

Overview:
- AXI4 write master: accepts an AXI-Stream input and writes it to memory as fixed-length INCR bursts into a circular address region.
- Write-side counterpart of the team's AXI burst reader; each completed burst raises o_wr_done, which feeds the reader's i_wr_done.
- Single clock domain; the stream and the AXI master share m_axi_aclk.

Parameters:
AW_FLIP_BYTE, 0, 1 = reverse byte order of stream data onto WDATA (byte 0 <-> byte N-1); 0 = pass through
AW_ADDR_WIDTH, 32, AXI address width
AW_DATA_WIDTH, 64, stream/AXI data width; 32, 64 or 128
AW_LEN, 16, beats per burst, 1-256
WR_START_ADDR, 32'h0000_0000, first burst address and wrap target
WR_END_ADDR, 32'h0001_0000, exclusive end of region
ADDR_STEP, 4096, address increment per burst in bytes

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  asynchronous active-low reset
S_WR_tdata  in  AW_DATA_WIDTH  stream data
S_WR_tvalid  in  1  stream valid
S_WR_tlast  in  1  stream last; checked only, does not frame bursts
S_WR_tready  out  1  stream ready
o_wr_done  out  1  one-cycle pulse per burst with OKAY response
o_bresp_err  out  1  sticky; set when BRESP != 0
o_tlast_err  out  1  sticky; set on tlast/beat-count mismatch
o_burst_cnt  out  32  count of completed bursts, including errored ones
m_axi_awid  out  1  constant 0
m_axi_awaddr  out  AW_ADDR_WIDTH  burst address
m_axi_awlen  out  8  AW_LEN-1
m_axi_awsize  out  3  clogb2(AW_DATA_WIDTH/8-1)
m_axi_awburst  out  2  2'b01 (INCR)
m_axi_awlock  out  1  0
m_axi_awcache  out  4  4'd3
m_axi_awprot  out  3  0
m_axi_awqos  out  4  0
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  AW_DATA_WIDTH  write data
m_axi_wstrb  out  AW_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bid  in  1  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset (async, active-low): FSM to IDLE; awvalid=0, wvalid=0, wlast=0, bready=0, S_WR_tready=0, o_wr_done=0, o_bresp_err=0, o_tlast_err=0, o_burst_cnt=0, beat_cnt=0, addr register=WR_START_ADDR. Reset mid-burst abandons the burst; no completion of the open AXI transaction is attempted.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_DONE.
- IDLE -> WR_ADDR when S_WR_tvalid=1. No data is consumed in IDLE or WR_ADDR.
- WR_ADDR: awvalid=1, awaddr=addr register. awaddr and awvalid are registered and held stable until awready. On awvalid&&awready -> WR_DATA next cycle; awvalid drops.
- WR_DATA:
  - Combinational: wvalid=S_WR_tvalid, S_WR_tready=m_axi_wready, wdata=(flipped) S_WR_tdata, wlast=(beat_cnt==AW_LEN-1).
  - A beat transfers when S_WR_tvalid&&m_axi_wready; beat_cnt increments on each transfer.
  - On the last-beat transfer: beat_cnt clears -> WR_RESP.
  - Outside WR_DATA: wvalid=0, S_WR_tready=0, wlast=0.
  - AW_LEN=1: wlast is high on the first beat.
- tlast check: on each transfer, if S_WR_tlast != wlast, set o_tlast_err. The flag is informational only and does not alter framing.
- WR_RESP: bready=1. On bvalid: if bresp != 2'b00, set o_bresp_err -> WR_DONE.
- WR_DONE (one cycle):
  - o_burst_cnt+1 (wraps at 2^32).
  - o_wr_done=1 for this cycle only if the response was OKAY.
  - addr register = (addr >= WR_END_ADDR-ADDR_STEP) ? WR_START_ADDR : addr+ADDR_STEP.
  - -> IDLE.
- Throughput: at least 2 idle cycles between bursts (WR_DONE, IDLE). A back-to-back stream is stalled via tready=0 during those cycles.
- Byte flip applies to WDATA only and is generic over AW_DATA_WIDTH/8 bytes.
- Single outstanding transaction; AW always precedes W.

Test Plan:
- Reset, then 16 beats data=0..15 with tlast on beat 15, awready/wready/bvalid always 1 -> awaddr=0x0, awlen=15, awsize=3, WDATA 0..15 in order, wlast only on beat 15, one o_wr_done pulse, o_burst_cnt=1, no error flags.
- 16 consecutive bursts -> awaddr sequence 0x0000, 0x1000 … 0xF000; 17th burst awaddr=0x0000 (wrap to WR_START_ADDR).
- Random stalls on S_WR_tvalid, m_axi_wready, awready (3 cycles), bvalid (5 cycles) -> no data lost or duplicated; awaddr and wdata stable while stalled; exactly 16 W handshakes.
- bresp=2'b10 on burst 2 -> o_bresp_err=1 and stays set; no o_wr_done for burst 2; o_burst_cnt=2; burst 3 proceeds at 0x2000.
- tlast asserted on beat 7 of 16 -> o_tlast_err=1; burst still ends on beat 15 with wlast.
- AW_FLIP_BYTE=1, data 64'h0102030405060708 -> WDATA 64'h0807060504030201. Reset asserted on beat 5 -> all outputs return to reset values; next burst awaddr=WR_START_ADDR.

Source files
------------

// File: rtl/axi_write_burst.sv
// axi_write_burst
// ---------------------------------------------------------------------------
// AXI4 write master that takes an AXI-Stream input and writes it to memory as
// fixed-length INCR bursts. Successive bursts walk through a circular address
// region [WR_START_ADDR, WR_END_ADDR) in ADDR_STEP increments. Each burst
// completed with an OKAY response pulses o_wr_done for one cycle.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A valid driven by this block is
// never withdrawn, and its payload never changes, until the matching ready.
// On the W channel, wvalid and wdata come straight from the stream, so their
// stability follows the stream source.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn      clock, asynchronous active-low reset
//   S_WR_t*                        AXI-Stream slave (tdata/tvalid/tlast/tready)
//   o_wr_done                      one-cycle pulse per OKAY burst
//   o_bresp_err, o_tlast_err       sticky error flags
//   o_burst_cnt                    completed bursts, errored ones included
//   m_axi_aw*, m_axi_w*, m_axi_b*  AXI4 write address / data / response
//   dbg_state_o                    current FSM state, for observation
// ---------------------------------------------------------------------------
module axi_write_burst #(
  parameter int                         AW_FLIP_BYTE  = 0,
  parameter int                         AW_ADDR_WIDTH = 32,
  parameter int                         AW_DATA_WIDTH = 64,
  parameter int                         AW_LEN        = 16,
  parameter logic [AW_ADDR_WIDTH-1:0]   WR_START_ADDR = 'h0000_0000,
  parameter logic [AW_ADDR_WIDTH-1:0]   WR_END_ADDR   = 'h0001_0000,
  parameter int                         ADDR_STEP     = 4096
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_aresetn,
  // stream input
  input  logic [AW_DATA_WIDTH-1:0]     S_WR_tdata,
  input  logic                         S_WR_tvalid,
  input  logic                         S_WR_tlast,
  output logic                         S_WR_tready,
  // status
  output logic                         o_wr_done,
  output logic                         o_bresp_err,
  output logic                         o_tlast_err,
  output logic [31:0]                  o_burst_cnt,
  // AXI write address
  output logic                         m_axi_awid,
  output logic [AW_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awlock,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic [3:0]                   m_axi_awqos,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  // AXI write data
  output logic [AW_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AW_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  // AXI write response
  input  logic                         m_axi_bid,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  // debug
  output logic [2:0]                   dbg_state_o
);

  localparam int NB = AW_DATA_WIDTH / 8;

  localparam logic [8:0]               LAST_BEAT = 9'(AW_LEN - 1);
  localparam logic [AW_ADDR_WIDTH-1:0] STEP      = AW_ADDR_WIDTH'(ADDR_STEP);
  // Once the address reaches this point the next burst would leave the region.
  localparam logic [AW_ADDR_WIDTH-1:0] WRAP_AT   = WR_END_ADDR - STEP;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_WR_RESP = 3'd3;
  localparam logic [2:0] S_WR_DONE = 3'd4;

  logic [2:0]               state_q,     state_d;
  logic [AW_ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                     awvalid_q,   awvalid_d;
  logic [8:0]               beat_cnt_q,  beat_cnt_d;
  logic [31:0]              burst_cnt_q, burst_cnt_d;
  logic                     bresp_err_q, bresp_err_d;
  logic                     tlast_err_q, tlast_err_d;
  logic                     resp_ok_q,   resp_ok_d;

  logic                     in_data;
  logic                     w_fire;
  logic [AW_DATA_WIDTH-1:0] wdata_mux;

  // The B channel ID is not needed with a single outstanding transaction.
  logic unused_bid;
  assign unused_bid = m_axi_bid;

  // Constant AW attributes.
  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = 8'(AW_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(NB));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd3;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;

  // The address register feeds AWADDR directly; it only changes in WR_DONE,
  // so it is stable for the whole time awvalid is high.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;

  // The W channel is a combinational pass-through of the stream while in
  // WR_DATA; outside it the stream is stalled.
  assign in_data      = (state_q == S_WR_DATA);
  assign m_axi_wvalid = in_data & S_WR_tvalid;
  assign S_WR_tready  = in_data & m_axi_wready;
  assign m_axi_wlast  = in_data & (beat_cnt_q == LAST_BEAT);
  assign w_fire       = in_data & S_WR_tvalid & m_axi_wready;
  assign m_axi_wdata  = wdata_mux;

  assign m_axi_bready = (state_q == S_WR_RESP);
  assign o_wr_done    = (state_q == S_WR_DONE) & resp_ok_q;
  assign o_bresp_err  = bresp_err_q;
  assign o_tlast_err  = tlast_err_q;
  assign o_burst_cnt  = burst_cnt_q;
  assign dbg_state_o  = state_q;

  // Optional byte reversal: byte 0 of the stream lands in byte NB-1 of WDATA.
  always_comb begin
    wdata_mux = S_WR_tdata;
    if (AW_FLIP_BYTE != 0) begin
      for (int b = 0; b < NB; b++) begin
        wdata_mux[b*8 +: 8] = S_WR_tdata[(NB-1-b)*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    awvalid_d   = awvalid_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    bresp_err_d = bresp_err_q;
    tlast_err_d = tlast_err_q;
    resp_ok_d   = resp_ok_q;
    case (state_q)
      S_IDLE: begin
        if (S_WR_tvalid) begin
          awvalid_d = 1'b1;
          state_d   = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_fire) begin
          // tlast is only cross-checked; the beat counter alone frames bursts.
          if (S_WR_tlast != m_axi_wlast) tlast_err_d = 1'b1;
          if (m_axi_wlast) begin
            beat_cnt_d = 9'd0;
            state_d    = S_WR_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_ok_d = (m_axi_bresp == 2'b00);
          if (m_axi_bresp != 2'b00) bresp_err_d = 1'b1;
          state_d = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        burst_cnt_d = burst_cnt_q + 32'd1;
        addr_d      = (addr_q >= WRAP_AT) ? WR_START_ADDR : addr_q + STEP;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= WR_START_ADDR;
      awvalid_q   <= 1'b0;
      beat_cnt_q  <= 9'd0;
      burst_cnt_q <= 32'd0;
      bresp_err_q <= 1'b0;
      tlast_err_q <= 1'b0;
      resp_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      awvalid_q   <= awvalid_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      bresp_err_q <= bresp_err_d;
      tlast_err_q <= tlast_err_d;
      resp_ok_q   <= resp_ok_d;
    end
  end

endmodule

// File: tb/tb_axi_write_burst.sv
// Testbench for axi_write_burst. A second instance with byte flipping enabled
// shares every input with the main instance; it must behave identically except
// for WDATA, which is byte-reversed.
module tb_axi_write_burst;

  localparam int DW = 64;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- shared DUT inputs ----------------
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, awready, wready, bid, bvalid;
  logic [1:0]    bresp;

  // ---------------- main DUT outputs ----------------
  logic          tready, wr_done, bresp_err, tlast_err;
  logic [31:0]   burst_cnt;
  logic          awid, awlock, awvalid, wlast, wvalid, bready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot, dbg_state;
  logic [1:0]    awburst;
  logic [3:0]    awcache, awqos;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;

  // ---------------- flip DUT outputs ----------------
  logic          f_tready, f_wr_done, f_bresp_err, f_tlast_err;
  logic [31:0]   f_burst_cnt;
  logic          f_awid, f_awlock, f_awvalid, f_wlast, f_wvalid, f_bready;
  logic [AW-1:0] f_awaddr;
  logic [7:0]    f_awlen;
  logic [2:0]    f_awsize, f_awprot, f_dbg_state;
  logic [1:0]    f_awburst;
  logic [3:0]    f_awcache, f_awqos;
  logic [DW-1:0] f_wdata;
  logic [7:0]    f_wstrb;

  axi_write_burst #(.AW_FLIP_BYTE(0)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .S_WR_tdata(tdata), .S_WR_tvalid(tvalid), .S_WR_tlast(tlast), .S_WR_tready(tready),
    .o_wr_done(wr_done), .o_bresp_err(bresp_err), .o_tlast_err(tlast_err), .o_burst_cnt(burst_cnt),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .dbg_state_o(dbg_state)
  );

  axi_write_burst #(.AW_FLIP_BYTE(1)) dut_flip (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .S_WR_tdata(tdata), .S_WR_tvalid(tvalid), .S_WR_tlast(tlast), .S_WR_tready(f_tready),
    .o_wr_done(f_wr_done), .o_bresp_err(f_bresp_err), .o_tlast_err(f_tlast_err), .o_burst_cnt(f_burst_cnt),
    .m_axi_awid(f_awid), .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen), .m_axi_awsize(f_awsize),
    .m_axi_awburst(f_awburst), .m_axi_awlock(f_awlock), .m_axi_awcache(f_awcache), .m_axi_awprot(f_awprot),
    .m_axi_awqos(f_awqos), .m_axi_awvalid(f_awvalid), .m_axi_awready(awready),
    .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb), .m_axi_wlast(f_wlast), .m_axi_wvalid(f_wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(f_bready), .dbg_state_o(f_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] beat_data [16];
  logic [DW-1:0] exp_q [$];

  // Per-burst observations filled in by do_burst.
  int            n_aw, n_w, n_done, data_err, wlast_err, stable_err, lock_err;
  logic [AW-1:0] aw_addr_seen;
  logic [DW-1:0] flip_first, pass_first;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_data(input logic [DW-1:0] base);
    for (int i = 0; i < 16; i++) beat_data[i] = base + DW'(i);
  endtask

  // Runs one burst of the 16 beats in beat_data. Inputs change on the falling
  // edge and outputs are sampled 1 time unit later, well before the rising edge
  // on which the handshakes sampled here take effect.
  task automatic do_burst(input bit stall, input logic [1:0] resp, input int tlast_beat,
                          input int abort_after);
    int k, aw_wait, b_wait, cyc;
    bit done_seen, b_hs_prev, aborted, prev_aw_pend, prev_w_pend;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd, exp_w;
    k = 0; aw_wait = 0; b_wait = 0; cyc = 0;
    done_seen = 0; b_hs_prev = 0; aborted = 0; prev_aw_pend = 0; prev_w_pend = 0;
    prev_addr = '0; prev_wd = '0;
    n_aw = 0; n_w = 0; n_done = 0; data_err = 0; wlast_err = 0; stable_err = 0; lock_err = 0;
    aw_addr_seen = '1; flip_first = '0; pass_first = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(beat_data[i]);
    while (!done_seen && !aborted && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      tvalid  = (k < 16) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      tdata   = (k < 16) ? beat_data[k] : '0;
      tlast   = (k == tlast_beat);
      wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (awvalid) aw_wait++;
      awready = stall ? (aw_wait > 3) : 1'b1;
      if (bready) b_wait++;
      bvalid  = stall ? (b_wait > 5) : 1'b1;
      bresp   = resp;
      #1;
      if (b_hs_prev) done_seen = 1;
      if (prev_aw_pend && (!awvalid || awaddr !== prev_addr)) stable_err++;
      if (prev_w_pend && wvalid && wdata !== prev_wd) stable_err++;
      if (awvalid && awready) begin
        n_aw++;
        aw_addr_seen = awaddr;
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) data_err++;
        else begin
          exp_w = exp_q.pop_front();
          if (wdata !== exp_w) data_err++;
        end
        if (wlast !== (n_w == 15)) wlast_err++;
        if (n_w == 0) begin
          flip_first = f_wdata;
          pass_first = wdata;
        end
        n_w++;
        k++;
      end
      if (bvalid && bready) b_hs_prev = 1;
      if (wr_done) n_done++;
      if ({f_awvalid, f_awaddr, f_wvalid, f_wlast, f_bready, f_tready, f_wr_done, f_burst_cnt,
           f_bresp_err, f_tlast_err, f_dbg_state, f_awid, f_awlen, f_awsize, f_awburst, f_awlock,
           f_awcache, f_awprot, f_awqos, f_wstrb} !==
          {awvalid, awaddr, wvalid, wlast, bready, tready, wr_done, burst_cnt,
           bresp_err, tlast_err, dbg_state, awid, awlen, awsize, awburst, awlock,
           awcache, awprot, awqos, wstrb}) lock_err++;
      prev_aw_pend = awvalid && !awready;
      prev_addr    = awaddr;
      prev_w_pend  = wvalid && !wready;
      prev_wd      = wdata;
      if (abort_after > 0 && n_w == abort_after) aborted = 1;
    end
    @(posedge clk);
    compared++;
    if (!done_seen && !aborted) begin
      mismatched++;
      $display("FAIL burst_timeout: burst did not complete within %0d cycles", cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    compared++; if ({awvalid, wvalid, wlast, bready, tready} !== 5'b0) begin mismatched++; $display("FAIL reset_handshake_outs: got %b exp 00000", {awvalid, wvalid, wlast, bready, tready}); end
    compared++; if ({wr_done, bresp_err, tlast_err} !== 3'b0) begin mismatched++; $display("FAIL reset_flags: got %b exp 000", {wr_done, bresp_err, tlast_err}); end
    compared++; if (burst_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_burst_cnt: got %0d exp 0", burst_cnt); end
    compared++; if (awaddr !== 32'h0) begin mismatched++; $display("FAIL reset_awaddr: got %h exp 00000000", awaddr); end
    compared++; if ({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos} !== {1'b0, 8'd15, 3'd3, 2'b01, 1'b0, 4'd3, 3'd0, 4'd0}) begin mismatched++; $display("FAIL aw_constants: got len=%0d size=%0d burst=%0d cache=%0d", awlen, awsize, awburst, awcache); end
    compared++; if (wstrb !== 8'hFF) begin mismatched++; $display("FAIL wstrb: got %h exp ff", wstrb); end
    release_reset();
  endtask

  task automatic test_single_burst();
    fill_data(64'd0);
    do_burst(1'b0, 2'b00, 15, 0);
    @(negedge clk);
    compared++; if (n_aw !== 1) begin mismatched++; $display("FAIL single_aw_count: got %0d exp 1", n_aw); end
    compared++; if (aw_addr_seen !== 32'h0) begin mismatched++; $display("FAIL single_awaddr: got %h exp 00000000", aw_addr_seen); end
    compared++; if (n_w !== 16) begin mismatched++; $display("FAIL single_w_count: got %0d exp 16", n_w); end
    compared++; if (data_err !== 0) begin mismatched++; $display("FAIL single_wdata: got %0d bad beats exp 0", data_err); end
    compared++; if (wlast_err !== 0) begin mismatched++; $display("FAIL single_wlast: got %0d misplaced exp 0", wlast_err); end
    compared++; if (n_done !== 1) begin mismatched++; $display("FAIL single_done_pulses: got %0d exp 1", n_done); end
    compared++; if (burst_cnt !== 32'd1) begin mismatched++; $display("FAIL single_burst_cnt: got %0d exp 1", burst_cnt); end
    compared++; if ({bresp_err, tlast_err} !== 2'b00) begin mismatched++; $display("FAIL single_err_flags: got %b exp 00", {bresp_err, tlast_err}); end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp_addr;
    for (int i = 1; i <= 16; i++) begin
      fill_data(64'h1000_0000 + 64'(i * 256));
      do_burst(1'b0, 2'b00, 15, 0);
      exp_addr = (i == 16) ? 32'h0000_0000 : 32'(i) * 32'h1000;
      compared++; if (aw_addr_seen !== exp_addr) begin mismatched++; $display("FAIL wrap_awaddr_%0d: got %h exp %h", i, aw_addr_seen, exp_addr); end
    end
    @(negedge clk);
    compared++; if (burst_cnt !== 32'd17) begin mismatched++; $display("FAIL wrap_burst_cnt: got %0d exp 17", burst_cnt); end
  endtask

  task automatic test_stalls();
    fill_data(64'hDEAD_0000_0000_0000);
    do_burst(1'b1, 2'b00, 15, 0);
    @(negedge clk);
    compared++; if (aw_addr_seen !== 32'h1000) begin mismatched++; $display("FAIL stall_awaddr: got %h exp 00001000", aw_addr_seen); end
    compared++; if (n_aw !== 1 || n_w !== 16) begin mismatched++; $display("FAIL stall_hs_counts: got aw=%0d w=%0d exp aw=1 w=16", n_aw, n_w); end
    compared++; if (data_err !== 0) begin mismatched++; $display("FAIL stall_wdata: got %0d bad beats exp 0", data_err); end
    compared++; if (stable_err !== 0) begin mismatched++; $display("FAIL stall_stability: got %0d changes exp 0", stable_err); end
    compared++; if (lock_err !== 0) begin mismatched++; $display("FAIL stall_lockstep: got %0d diffs exp 0", lock_err); end
    compared++; if (n_done !== 1 || burst_cnt !== 32'd18) begin mismatched++; $display("FAIL stall_done: got pulses=%0d cnt=%0d exp 1 18", n_done, burst_cnt); end
  endtask

  task automatic test_bresp_err();
    apply_reset();
    release_reset();
    fill_data(64'h100);
    do_burst(1'b0, 2'b00, 15, 0);
    fill_data(64'h200);
    do_burst(1'b0, 2'b10, 15, 0);
    @(negedge clk);
    compared++; if (n_done !== 0) begin mismatched++; $display("FAIL bresp_no_done: got %0d pulses exp 0", n_done); end
    compared++; if (bresp_err !== 1'b1) begin mismatched++; $display("FAIL bresp_flag: got %b exp 1", bresp_err); end
    compared++; if (burst_cnt !== 32'd2) begin mismatched++; $display("FAIL bresp_burst_cnt: got %0d exp 2", burst_cnt); end
    fill_data(64'h300);
    do_burst(1'b0, 2'b00, 15, 0);
    @(negedge clk);
    compared++; if (aw_addr_seen !== 32'h2000) begin mismatched++; $display("FAIL bresp_next_awaddr: got %h exp 00002000", aw_addr_seen); end
    compared++; if (n_done !== 1 || bresp_err !== 1'b1) begin mismatched++; $display("FAIL bresp_sticky: got pulses=%0d err=%b exp 1 1", n_done, bresp_err); end
  endtask

  task automatic test_tlast_err();
    compared++; if (tlast_err !== 1'b0) begin mismatched++; $display("FAIL tlast_pre: got %b exp 0", tlast_err); end
    fill_data(64'h400);
    do_burst(1'b0, 2'b00, 7, 0);
    @(negedge clk);
    compared++; if (tlast_err !== 1'b1) begin mismatched++; $display("FAIL tlast_flag: got %b exp 1", tlast_err); end
    compared++; if (n_w !== 16 || wlast_err !== 0) begin mismatched++; $display("FAIL tlast_framing: got beats=%0d wlast_err=%0d exp 16 0", n_w, wlast_err); end
    compared++; if (burst_cnt !== 32'd4) begin mismatched++; $display("FAIL tlast_burst_cnt: got %0d exp 4", burst_cnt); end
  endtask

  task automatic test_flip_and_mid_reset();
    apply_reset();
    release_reset();
    fill_data(64'h0);
    beat_data[0] = 64'h0102030405060708;
    do_burst(1'b0, 2'b00, 15, 0);
    compared++; if (flip_first !== 64'h0807060504030201) begin mismatched++; $display("FAIL flip_wdata: got %h exp 0807060504030201", flip_first); end
    compared++; if (pass_first !== 64'h0102030405060708) begin mismatched++; $display("FAIL noflip_wdata: got %h exp 0102030405060708", pass_first); end
    // Abandon the second burst after 5 beats and reset.
    fill_data(64'h500);
    do_burst(1'b0, 2'b00, 15, 5);
    @(negedge clk);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    #1;
    compared++; if ({awvalid, wvalid, wlast, bready, tready, wr_done, bresp_err, tlast_err} !== 8'b0) begin mismatched++; $display("FAIL midreset_outs: got %b exp 00000000", {awvalid, wvalid, wlast, bready, tready, wr_done, bresp_err, tlast_err}); end
    compared++; if (burst_cnt !== 32'd0 || awaddr !== 32'h0) begin mismatched++; $display("FAIL midreset_regs: got cnt=%0d addr=%h exp 0 00000000", burst_cnt, awaddr); end
    repeat (2) @(posedge clk);
    release_reset();
    fill_data(64'h600);
    do_burst(1'b0, 2'b00, 15, 0);
    @(negedge clk);
    compared++; if (aw_addr_seen !== 32'h0) begin mismatched++; $display("FAIL midreset_next_awaddr: got %h exp 00000000", aw_addr_seen); end
    compared++; if (n_w !== 16 || data_err !== 0 || burst_cnt !== 32'd1) begin mismatched++; $display("FAIL midreset_next_burst: got beats=%0d bad=%0d cnt=%0d exp 16 0 1", n_w, data_err, burst_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 1'b0;
    test_reset();
    test_single_burst();
    test_addr_wrap();
    test_stalls();
    test_bresp_err();
    test_tlast_err();
    test_flip_and_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
